// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI frame controller.
package spi_ctrl_pkg;

  localparam int unsigned MAX_PIXEL_BITS = 8;
  localparam int unsigned CMD_BITS       = 2;

  typedef enum logic [CMD_BITS-1:0] {
    CMD_NOP    = 2'd0,
    CMD_WRITE  = 2'd1,
    CMD_READ   = 2'd2,
    CMD_STATUS = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_READ,
    ST_STATUS
  } state_e;

  // Status word layout: {zeros, fifo_count, ovf, drop}
  localparam int unsigned STAT_DROP_BIT = 0;
  localparam int unsigned STAT_OVF_BIT  = 1;
  localparam int unsigned STAT_CNT_LSB  = 2;

endpackage

// File: rtl/spi_frame_ctrl_result_fifo.sv
// Synchronous result FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module result_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spi_frame_ctrl.sv
// Frame controller for spi_core: synchronizes CS/word-done, decodes the first word
// of each CS frame as a command and routes pixels, FIFO results or status to the SPI.
module spi_frame_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = MAX_PIXEL_BITS,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 cs_i,
  input  logic                 rxtx_done_i,
  input  logic [WORD_SIZE-1:0] data_rx_i,
  output logic [WORD_SIZE-1:0] data_tx_o,
  output logic [WORD_SIZE-1:0] pixel_o,
  output logic                 pixel_valid_o,
  input  logic                 pixel_ready_i,
  input  logic [WORD_SIZE-1:0] result_i,
  input  logic                 result_valid_i,
  output logic                 busy_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]           r_cs_sync;
  logic                 r_cs_d;
  logic [1:0]           r_done_sync;
  logic                 r_done_d;
  logic                 r_word_stb;
  state_e               r_state;
  state_e               w_state_next;
  logic                 r_drop;
  logic                 r_ovf;

  logic                 w_cs_n;
  logic                 w_cs_fall;
  logic                 w_cs_rise;
  logic                 w_stb;
  cmd_e                 w_cmd;
  logic                 w_tx_load;
  logic [WORD_SIZE-1:0] w_tx_next;
  logic                 w_pop;
  logic                 w_pix_load;
  logic                 w_drop_set;
  logic                 w_ovf_set;
  logic                 w_flag_clr;
  logic [WORD_SIZE-1:0] w_status;
  logic [WORD_SIZE-1:0] w_head;
  logic [WORD_SIZE-1:0] w_fifo_data;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [CNT_W-1:0]     w_fifo_count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cs_sync   <= 2'b11;
      r_cs_d      <= 1'b1;
      r_done_sync <= '0;
      r_done_d    <= 1'b0;
      r_word_stb  <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[0], cs_i};
      r_cs_d      <= r_cs_sync[1];
      r_done_sync <= {r_done_sync[0], rxtx_done_i};
      r_done_d    <= r_done_sync[1];
      r_word_stb  <= r_done_sync[1] & ~r_done_d;
    end
  end

  assign w_cs_n    = r_cs_sync[1];
  assign w_cs_fall = r_cs_d & ~w_cs_n;
  assign w_cs_rise = ~r_cs_d & w_cs_n;
  // Word strobes arriving while the frame is closed are not acted on.
  assign w_stb     = r_word_stb & ~w_cs_n;
  assign w_cmd     = cmd_e'(data_rx_i[CMD_BITS-1:0]);
  assign busy_o    = (r_state != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_cs_rise) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_cs_fall) w_state_next = ST_CMD;
        ST_CMD: begin
          if (w_stb) begin
            case (w_cmd)
              CMD_WRITE: w_state_next = ST_WRITE;
              CMD_READ:  w_state_next = ST_READ;
              default:   w_state_next = ST_STATUS;
            endcase
          end
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_status = '0;
    w_status[STAT_DROP_BIT] = r_drop;
    w_status[STAT_OVF_BIT]  = r_ovf;
    w_status[STAT_CNT_LSB +: CNT_W] = w_fifo_count;
  end

  assign w_head = w_fifo_empty ? '0 : w_fifo_data;

  always_comb begin
    w_tx_load  = 1'b0;
    w_tx_next  = '0;
    w_pop      = 1'b0;
    w_pix_load = 1'b0;
    w_drop_set = 1'b0;
    w_flag_clr = 1'b0;
    if (w_stb) begin
      w_tx_load = 1'b1;
      case (r_state)
        ST_CMD: begin
          case (w_cmd)
            CMD_READ: begin
              w_pop     = 1'b1;
              w_tx_next = w_head;
            end
            CMD_STATUS: begin
              w_tx_next  = w_status;
              w_flag_clr = 1'b1;
            end
            default: w_tx_next = '0;
          endcase
        end
        ST_READ: begin
          w_pop     = 1'b1;
          w_tx_next = w_head;
        end
        ST_WRITE: begin
          if (pixel_valid_o) w_drop_set = 1'b1;
          else               w_pix_load = 1'b1;
        end
        default: w_tx_next = '0;
      endcase
    end
  end

  // A full FIFO only overflows if no pop frees a slot in the same cycle.
  assign w_ovf_set = result_valid_i & w_fifo_full & ~w_pop;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_tx_o     <= '0;
      pixel_o       <= '0;
      pixel_valid_o <= 1'b0;
      r_drop        <= 1'b0;
      r_ovf         <= 1'b0;
    end else begin
      if (w_tx_load) data_tx_o <= w_tx_next;
      if (w_pix_load) begin
        pixel_o       <= data_rx_i;
        pixel_valid_o <= 1'b1;
      end else if (pixel_ready_i) begin
        pixel_valid_o <= 1'b0;
      end
      r_drop <= w_drop_set | (r_drop & ~w_flag_clr);
      r_ovf  <= w_ovf_set  | (r_ovf  & ~w_flag_clr);
    end
  end

  result_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_reset (reset_i),
    .i_push  (result_valid_i),
    .i_data  (result_i),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: table-driven frames plus hand-written FIFO/abort sequences.
module tb_spi_frame_ctrl;

  logic       clk;
  logic       reset_i;
  logic       cs_i;
  logic       rxtx_done_i;
  logic [7:0] data_rx_i;
  logic [7:0] data_tx_o;
  logic [7:0] pixel_o;
  logic       pixel_valid_o;
  logic       pixel_ready_i;
  logic [7:0] result_i;
  logic       result_valid_i;
  logic       busy_o;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [7:0]  hs_q[$];

  spi_frame_ctrl #(
    .WORD_SIZE  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .cs_i           (cs_i),
    .rxtx_done_i    (rxtx_done_i),
    .data_rx_i      (data_rx_i),
    .data_tx_o      (data_tx_o),
    .pixel_o        (pixel_o),
    .pixel_valid_o  (pixel_valid_o),
    .pixel_ready_i  (pixel_ready_i),
    .result_i       (result_i),
    .result_valid_i (result_valid_i),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset_i && pixel_valid_o && pixel_ready_i) hs_q.push_back(pixel_o);
  end

  typedef struct {
    logic        cs_n;
    logic        word_en;
    logic [7:0]  rx;
    logic        rdy;
    logic [7:0]  exp_tx;
    logic [7:0]  exp_pix;
    logic        exp_vld;
    logic        exp_busy;
    int unsigned exp_hs;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w);
    @(negedge clk);
    data_rx_i   = w;
    rxtx_done_i = 1'b1;
    repeat (4) @(negedge clk);
    rxtx_done_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Word whose strobe-driven pop lands in the same cycle as a result push.
  task automatic send_word_push(input logic [7:0] w, input logic [7:0] r);
    @(negedge clk);
    data_rx_i   = w;
    rxtx_done_i = 1'b1;
    repeat (3) @(negedge clk);
    result_i       = r;
    result_valid_i = 1'b1;
    @(negedge clk);
    result_valid_i = 1'b0;
    rxtx_done_i    = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] r);
    @(negedge clk);
    result_i       = r;
    result_valid_i = 1'b1;
    @(negedge clk);
    result_valid_i = 1'b0;
  endtask

  task automatic status_frame(input string name, input logic [7:0] exp);
    cs_i = 1'b0;
    cycles(4);
    send_word(8'h03);
    chk(name, data_tx_o, exp);
    cs_i = 1'b1;
    cycles(4);
  endtask

  initial begin
    reset_i        = 1'b1;
    cs_i           = 1'b1;
    rxtx_done_i    = 1'b0;
    data_rx_i      = '0;
    pixel_ready_i  = 1'b0;
    result_i       = '0;
    result_valid_i = 1'b0;

    //            cs  we  rx     rdy  tx     pix    vld busy hs
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 0};
    vecs[1]  = '{1'b0, 1'b1, 8'h01, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 0};
    vecs[2]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 8'h00, 8'hA5, 1'b0, 1'b1, 1};
    vecs[3]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 8'h00, 8'h3C, 1'b0, 1'b1, 2};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h3C, 1'b0, 1'b0, 2};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b1, 2};
    vecs[6]  = '{1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b1, 2};
    vecs[7]  = '{1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 8'h55, 1'b1, 1'b1, 2};
    vecs[8]  = '{1'b0, 1'b1, 8'h66, 1'b0, 8'h00, 8'h55, 1'b1, 1'b1, 2};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h55, 1'b1, 1'b0, 2};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h55, 1'b0, 1'b1, 3};
    vecs[11] = '{1'b0, 1'b1, 8'h03, 1'b1, 8'h01, 8'h55, 1'b0, 1'b1, 3};
    vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 8'h55, 1'b0, 1'b0, 3};
    vecs[13] = '{1'b0, 1'b1, 8'h03, 1'b1, 8'h00, 8'h55, 1'b0, 1'b1, 3};
    vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h55, 1'b0, 1'b0, 3};
    vecs[15] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 8'h55, 1'b0, 1'b1, 3};
    vecs[16] = '{1'b0, 1'b1, 8'h01, 1'b1, 8'h00, 8'h55, 1'b0, 1'b1, 3};
    vecs[17] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h55, 1'b0, 1'b0, 3};

    cycles(3);
    reset_i = 1'b0;
    chk("rst_tx",   data_tx_o,     8'h00);
    chk("rst_pix",  pixel_o,       8'h00);
    chk("rst_vld",  pixel_valid_o, 1'b0);
    chk("rst_busy", busy_o,        1'b0);

    // Reset in the middle of a WRITE frame with a pixel pending and a result queued
    cs_i = 1'b0;
    cycles(4);
    send_word(8'h01);
    send_word(8'h77);
    chk("wr_pend_pix", pixel_o,       8'h77);
    chk("wr_pend_vld", pixel_valid_o, 1'b1);
    push(8'h99);
    reset_i = 1'b1;
    cycles(2);
    reset_i = 1'b0;
    cs_i    = 1'b1;
    chk("midrst_tx",   data_tx_o,     8'h00);
    chk("midrst_pix",  pixel_o,       8'h00);
    chk("midrst_vld",  pixel_valid_o, 1'b0);
    chk("midrst_busy", busy_o,        1'b0);
    cycles(4);

    for (int i = 0; i < 18; i++) begin
      cs_i          = vecs[i].cs_n;
      pixel_ready_i = vecs[i].rdy;
      cycles(4);
      if (vecs[i].word_en) send_word(vecs[i].rx);
      chk($sformatf("v%0d_tx",   i), data_tx_o,     vecs[i].exp_tx);
      chk($sformatf("v%0d_pix",  i), pixel_o,       vecs[i].exp_pix);
      chk($sformatf("v%0d_vld",  i), pixel_valid_o, vecs[i].exp_vld);
      chk($sformatf("v%0d_busy", i), busy_o,        vecs[i].exp_busy);
      chk($sformatf("v%0d_hs",   i), hs_q.size(),   vecs[i].exp_hs);
    end
    if (hs_q.size() == 3) begin
      chk("hs0", hs_q[0], 8'hA5);
      chk("hs1", hs_q[1], 8'h3C);
      chk("hs2", hs_q[2], 8'h55);
    end else begin
      chk("hs_count", hs_q.size(), 3);
    end

    // READ of two queued results, then empty
    push(8'h11);
    push(8'h22);
    cs_i = 1'b0;
    cycles(4);
    chk("rd_miso0", data_tx_o, 8'h00);
    send_word(8'h02);
    chk("rd_miso1", data_tx_o, 8'h11);
    send_word(8'hFF);
    chk("rd_miso2", data_tx_o, 8'h22);
    send_word(8'hFF);
    chk("rd_miso3", data_tx_o, 8'h00);
    cs_i = 1'b1;
    cycles(4);
    status_frame("rd_status_empty", 8'h00);

    // Overflow: five pushes into four entries
    for (int i = 1; i <= 5; i++) push(8'(i));
    status_frame("ovf_status", 8'h12);
    status_frame("ovf_cleared", 8'h10);

    // Push into the full FIFO in the same cycle as a READ pop
    cs_i = 1'b0;
    cycles(4);
    send_word_push(8'h02, 8'h66);
    chk("pp_head", data_tx_o, 8'h01);
    cs_i = 1'b1;
    cycles(4);
    status_frame("pp_status", 8'h10);
    cs_i = 1'b0;
    cycles(4);
    send_word(8'h02);
    chk("pp_rd0", data_tx_o, 8'h02);
    send_word(8'hFF);
    chk("pp_rd1", data_tx_o, 8'h03);
    send_word(8'hFF);
    chk("pp_rd2", data_tx_o, 8'h04);
    send_word(8'hFF);
    chk("pp_rd3", data_tx_o, 8'h66);
    send_word(8'hFF);
    chk("pp_rd4", data_tx_o, 8'h00);
    cs_i = 1'b1;
    cycles(4);

    // Frame aborted mid-word, then a clean STATUS frame
    push(8'h5A);
    cs_i = 1'b0;
    cycles(4);
    send_word(8'h01);
    chk("abort_busy_in", busy_o, 1'b1);
    cycles(2);
    cs_i = 1'b1;
    cycles(4);
    chk("abort_idle", busy_o, 1'b0);
    status_frame("abort_status", 8'h04);
    send_word(8'h01);
    chk("cs_high_tx",   data_tx_o,     8'h04);
    chk("cs_high_pix",  pixel_o,       8'h55);
    chk("cs_high_vld",  pixel_valid_o, 1'b0);
    chk("cs_high_busy", busy_o,        1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_ctrl.md
# spi_frame_ctrl

Controller that sequences `spi_core` from the system clock domain. It synchronizes the SPI word-done pulse and chip select, and decodes the first word of every CS frame as a command. Depending on the command, it forwards subsequent words as pixels into the grayscale/Sobel pipeline, returns buffered pipeline results, or returns a status word on `data_tx`. It sits between `spi_core` and the pixel pipeline top.

## Interface
Parameters:
- `WORD_SIZE`, default `MAX_PIXEL_BITS`: SPI word and pixel width; must be ≥ 8.
- `FIFO_DEPTH`, default 4: result FIFO entries; power of two.

Ports:
- `clk_i` in 1: system clock; one clock for the whole block.
- `reset_i` in 1: synchronous, active-high reset.
- `cs_i` in 1: SPI chip select, active low, asynchronous to `clk_i`.
- `rxtx_done_i` in 1: word-done from `spi_core`, SCK domain.
- `data_rx_i` in `WORD_SIZE`: received word from `spi_core`.
- `data_tx_o` out `WORD_SIZE`: next word for `spi_core` to transmit.
- `pixel_o` out `WORD_SIZE`: pixel to pipeline.
- `pixel_valid_o` out 1: pixel valid.
- `pixel_ready_i` in 1: pipeline accepts pixel.
- `result_i` in `WORD_SIZE`: pipeline result.
- `result_valid_i` in 1: result valid; no backpressure.
- `busy_o` out 1: high when state ≠ IDLE.

## Operation
- Synchronizers: 2-flop sync on `cs_i` and on `rxtx_done_i`. A rising edge of the synced done produces a one-cycle `word_stb`; `data_rx_i` is captured on `word_stb`.
- Command field is `word[1:0]`; other bits are ignored. Codes: NOP=0, WRITE=1, READ=2, STATUS=3.
- FSM states: IDLE, CMD, WRITE, READ, STATUS.
  - IDLE → CMD when synced CS falls.
  - CMD → decoded state on `word_stb`. NOP → WRITE/READ/STATUS are not entered; NOP stays in CMD-consumed state, equivalent to STATUS, with tx=0.
  - Any state → IDLE when synced CS rises. This aborts the frame: a pending pixel stays valid until accepted, and FIFO contents are kept.
- WRITE: each `word_stb` loads `pixel_o` and sets `pixel_valid_o`. `pixel_valid_o` clears on a cycle with `pixel_ready_i`=1. If `pixel_valid_o` is still high at a new `word_stb`, the new word is dropped and sticky `drop` is set.
- Result FIFO: a push occurs on `result_valid_i`. When full, the push is discarded and sticky `ovf` is set, except when a pop occurs in the same cycle; then both happen and no overflow is flagged.
- READ: on the command strobe and on every `word_stb` in READ, `data_tx_o` ← FIFO head and pop; if the FIFO is empty, `data_tx_o` ← 0.
- STATUS: on the command strobe, `data_tx_o` ← {zeros, fifo_count, ovf, drop} (bit0=`drop`, bit1=`ovf`, bits from 2 upward=count). `drop` and `ovf` clear in the same cycle; a set in that same cycle wins. Later words in STATUS load 0.
- WRITE/NOP/IDLE: `data_tx_o` ← 0 on `word_stb`.
- Protocol consequence: `spi_core` loads `data_tx` at word end, so a response appears in the SPI word following the one that triggered it.

## Timing
- Required clock ratio: f_clk ≥ 8 × f_sck, which guarantees capture and the `data_tx_o` update before the next SCK edge.
- `word_stb` occurs 3 `clk_i` cycles after `rxtx_done_i` rises; `data_tx_o` and `pixel_o` update 1 cycle after `word_stb`.
- CS edges are seen 2 cycles late.
- Reset values: `data_tx_o`=0, `pixel_o`=0, `pixel_valid_o`=0, `busy_o`=0. State=IDLE, FIFO empty, `drop`=`ovf`=0, synchronizers=0 (CS sync resets to 1).
- A `word_stb` with CS deasserted (synced) is ignored.

## Structure
- Package `spi_ctrl_pkg`: `cmd_e` (NOP/WRITE/READ/STATUS codes), `state_e`, `CMD_BITS`=2, status bit positions.
- Sub-module `result_fifo`: synchronous FIFO with push/pop/full/empty/count and simultaneous push+pop when full.
- Synchronizers and FSM are inline.

## Test plan
- Reset mid-frame in WRITE with pixel pending → all outputs 0, state IDLE, FIFO empty.
- CS low, send 0x01, 0xA5, 0x3C with `pixel_ready_i`=1 → two pixel handshakes of 0xA5 and 0x3C; `data_tx_o` stays 0.
- WRITE with `pixel_ready_i`=0, send two pixels → first held valid, second dropped. Then STATUS → tx word bit0=1; a second STATUS → bit0=0.
- Push results 0x11, 0x22; frame 0x02, x, x, x → MISO words are 0x00, 0x11, 0x22, 0x00; FIFO empty.
- Push 5 results into depth 4 → `ovf`=1, count=4. Push on a full FIFO during a READ pop in the same cycle → no `ovf`, count unchanged.
- CS raised after 4 of 8 bits → state IDLE. Next frame 0x03 decodes correctly as STATUS.
